// File: rtl/serial_tx_pkg.sv
// Shared serial-link constants: FSM encodings, default oversampling rate and
// bit index numbering common to the transmit and receive paths.
package serial_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DEF_SAMPLES_PER_BIT = 16;

    localparam logic [3:0] START_IDX = 4'd0;
    localparam logic [3:0] STOP_IDX  = 4'd9;

endpackage

// File: rtl/tx_interval_counter.sv
// Sample counter for the transmitter: counts enabled cycles within a bit and
// strobes bit_end on the last sample of each bit period.
module tx_interval_counter #(
    parameter int SAMPLES_PER_BIT = 16
) (
    input  logic sr_clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    input  logic run,
    output logic bit_end
);

    localparam int CW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign bit_end = enable && run && (cnt == CW'(SAMPLES_PER_BIT - 1));

    always_ff @(posedge sr_clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && run) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DATA_BITS LSB-first, stop bit, each bit
// held SAMPLES_PER_BIT enabled cycles. tx is registered and idles high.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
    parameter int DATA_BITS       = 8
) (
    input  logic                 sr_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           bit_index
);

    logic [1:0]           state;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nx;
    logic                 accept;
    logic                 bit_end;

    assign busy     = (state != ST_IDLE);
    assign accept   = enable && load && (state == ST_IDLE);
    assign shreg_nx = shreg >> 1;

    tx_interval_counter #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_cnt (
        .sr_clk (sr_clk),
        .reset  (reset),
        .enable (enable),
        .clear  (accept),
        .run    (busy),
        .bit_end(bit_end)
    );

    // tx is loaded with the level of the upcoming bit on each bit boundary so
    // the line changes exactly on the boundary edge.
    always_ff @(posedge sr_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            tx        <= 1'b1;
            done      <= 1'b0;
            bit_index <= START_IDX;
        end else begin
            done <= 1'b0;
            if (accept) begin
                shreg     <= data_in;
                state     <= ST_START;
                tx        <= 1'b0;
                bit_index <= START_IDX;
            end else if (bit_end) begin
                case (state)
                    ST_START: begin
                        state     <= ST_DATA;
                        bit_index <= 4'd1;
                        tx        <= shreg[0];
                    end
                    ST_DATA: begin
                        if (bit_index == 4'(DATA_BITS)) begin
                            state     <= ST_STOP;
                            bit_index <= STOP_IDX;
                            tx        <= 1'b1;
                        end else begin
                            shreg     <= shreg_nx;
                            tx        <= shreg_nx[0];
                            bit_index <= bit_index + 4'd1;
                        end
                    end
                    ST_STOP: begin
                        state     <= ST_IDLE;
                        bit_index <= START_IDX;
                        tx        <= 1'b1;
                        done      <= 1'b1;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        bit_index <= START_IDX;
                        tx        <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
